// File: rtl/csa_sub_pipe.sv
// Two-stage pipelined subtractor d = a - b - bin built from carry-select blocks, valid/ready handshake.
// Optional macro SUB_SATURATE_EN clamps borrowing results to zero and raises sat.
module csa_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             sat
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned NB   = HALF / BLK;

  logic s1_valid, s2_valid;
  logic s1_load, s2_load;

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_valid = s2_valid;

  // Stage 1 combinational: resolve low half, precompute both upper-block candidates
  logic [HALF-1:0]          lo_sum_n;
  logic                     c_mid_n;
  logic [NB-1:0][BLK-1:0]   sum0_n, sum1_n;
  logic [NB-1:0]            car0_n, car1_n;

  always_comb begin
    logic            c;
    logic [BLK:0]    t;
    logic [BLK:0]    t0;
    logic [BLK:0]    t1;
    logic [BLK-1:0]  x;
    logic [BLK-1:0]  y;
    lo_sum_n = '0;
    sum0_n   = '0;
    sum1_n   = '0;
    car0_n   = '0;
    car1_n   = '0;
    c        = ~bin;
    t        = '0;
    t0       = '0;
    t1       = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      x = a[i*BLK +: BLK];
      y = ~b[i*BLK +: BLK];
      t = {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, c};
      lo_sum_n[i*BLK +: BLK] = t[BLK-1:0];
      c = t[BLK];
    end
    c_mid_n = c;
    for (int unsigned j = 0; j < NB; j++) begin
      x  = a[HALF + j*BLK +: BLK];
      y  = ~b[HALF + j*BLK +: BLK];
      t0 = {1'b0, x} + {1'b0, y};
      t1 = {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, 1'b1};
      sum0_n[j] = t0[BLK-1:0];
      car0_n[j] = t0[BLK];
      sum1_n[j] = t1[BLK-1:0];
      car1_n[j] = t1[BLK];
    end
  end

  logic [HALF-1:0]        s1_lo;
  logic                   s1_cmid;
  logic [NB-1:0][BLK-1:0] s1_sum0, s1_sum1;
  logic [NB-1:0]          s1_car0, s1_car1;
  logic                   s1_a_msb, s1_nb_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_cmid   <= 1'b0;
      s1_sum0   <= '0;
      s1_sum1   <= '0;
      s1_car0   <= '0;
      s1_car1   <= '0;
      s1_a_msb  <= 1'b0;
      s1_nb_msb <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo     <= lo_sum_n;
        s1_cmid   <= c_mid_n;
        s1_sum0   <= sum0_n;
        s1_sum1   <= sum1_n;
        s1_car0   <= car0_n;
        s1_car1   <= car1_n;
        s1_a_msb  <= a[WIDTH-1];
        s1_nb_msb <= ~b[WIDTH-1];
      end
    end
  end

  // Stage 2 combinational: ripple c_mid through the upper-block select muxes
  logic [WIDTH-1:0] d_raw, d_n;
  logic [HALF-1:0]  hi;
  logic             bout_n, ovf_n, sat_n, zero_n, neg_n;

  always_comb begin
    logic c;
    hi = '0;
    c  = s1_cmid;
    for (int unsigned j = 0; j < NB; j++) begin
      hi[j*BLK +: BLK] = c ? s1_sum1[j] : s1_sum0[j];
      c = c ? s1_car1[j] : s1_car0[j];
    end
    d_raw  = {hi, s1_lo};
    bout_n = ~c;
    // a and b signs differ exactly when a_msb equals the inverted b_msb
    ovf_n  = (s1_a_msb == s1_nb_msb) && (d_raw[WIDTH-1] != s1_a_msb);
`ifdef SUB_SATURATE_EN
    d_n    = bout_n ? '0 : d_raw;
    sat_n  = bout_n;
`else
    d_n    = d_raw;
    sat_n  = 1'b0;
`endif
    zero_n = (d_n == '0);
    neg_n  = d_n[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      d        <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      sat      <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        d    <= d_n;
        bout <= bout_n;
        zero <= zero_n;
        neg  <= neg_n;
        ovf  <= ovf_n;
        sat  <= sat_n;
      end
    end
  end

endmodule
